// File: rtl/ascii_lane_counter.sv
// ascii_lane_counter: LANES consecutive decimal counters kept in BCD, each
// presented as a zero-padded ASCII string plus its significant-digit count.
// Lane i always holds base+i, and every advance adds LANES to every lane.
module ascii_lane_counter #(
    parameter int LANES       = 4,
    parameter int DIGITS      = 7,
    parameter int START_VALUE = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_en,
    input  logic [4*DIGITS-1:0]                  load_value,
    input  logic                                 count_en,
    output logic                                 lanes_valid,
    output logic [LANES*8*DIGITS-1:0]            lane_ascii,
    output logic [LANES*$clog2(DIGITS+1)-1:0]    lane_digits,
    output logic                                 overflow,
    output logic                                 load_error
);

    localparam int DW = $clog2(DIGITS + 1);

    typedef logic [4*DIGITS-1:0] bcd_t;
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALT} state_t;

    // Integer to BCD; only ever called with elaboration-time constants.
    function automatic bcd_t to_bcd(input int value);
        bcd_t r;
        int   v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Nibble-wise BCD add with decimal carry ripple; carry is the carry out
    // of the most significant digit, i.e. the sum exceeded 10**DIGITS-1.
    function automatic bcd_t bcd_add(input bcd_t a, input bcd_t b, output logic carry);
        bcd_t       r;
        logic [4:0] s;
        logic       c;
        r = '0;
        c = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            s = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0, c};
            if (s > 5'd9) begin
                r[4*d +: 4] = 4'(s - 5'd10);
                c           = 1'b1;
            end else begin
                r[4*d +: 4] = s[3:0];
                c           = 1'b0;
            end
        end
        carry = c;
        return r;
    endfunction

    state_t        state_q, state_d;
    bcd_t          lane_q    [LANES];
    bcd_t          lane_d    [LANES];
    bcd_t          load_lane [LANES];
    bcd_t          step_lane [LANES];
    logic          load_carry, step_carry, load_bad;
    logic          overflow_d, load_error_d;
    logic [DW-1:0] cnt;

    assign lanes_valid = (state_q == ST_RUN);

    // Next state, next lane values and next sticky flags.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        lane_d       = lane_q;
        overflow_d   = overflow;
        load_error_d = load_error;
        load_carry   = 1'b0;
        step_carry   = 1'b0;
        load_bad     = 1'b0;

        for (int d = 0; d < DIGITS; d++) begin
            if (load_value[4*d +: 4] > 4'd9) load_bad = 1'b1;
        end

        // The last iteration leaves the carry of the highest lane behind;
        // that lane is the only one that can run past the top.
        for (int i = 0; i < LANES; i++) begin
            load_lane[i] = bcd_add(load_value, to_bcd(i), load_carry);
            step_lane[i] = bcd_add(lane_q[i], to_bcd(LANES), step_carry);
        end

        if (load_en) begin
            overflow_d   = 1'b0;
            load_error_d = 1'b0;
            if (load_bad) begin
                load_error_d = 1'b1;
                state_d      = ST_HALT;
            end else begin
                lane_d = load_lane;
                if (load_carry) begin
                    overflow_d = 1'b1;
                    state_d    = ST_HALT;
                end else begin
                    state_d = ST_INIT;
                end
            end
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_RUN;
                ST_RUN: begin
                    if (count_en) begin
                        if (step_carry) begin
                            overflow_d = 1'b1;
                            state_d    = ST_HALT;
                        end else begin
                            lane_d = step_lane;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, lane and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_INIT;
            overflow   <= 1'b0;
            load_error <= 1'b0;
            // NOTE: the lane registers are ordinary flops that must come up
            // holding START_VALUE+i, so they are reset along with the FSM.
            for (int i = 0; i < LANES; i++) lane_q[i] <= to_bcd(START_VALUE + i);
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            state_q    <= state_d;
            overflow   <= overflow_d;
            load_error <= load_error_d;
            lane_q     <= lane_d;
        end
    end

    // ASCII strings and significant-digit counts decoded from the lane registers.
    always_comb begin
        lane_ascii  = '0;
        lane_digits = '0;
        cnt         = '0;
        for (int i = 0; i < LANES; i++) begin
            cnt = DW'(1);
            for (int d = 0; d < DIGITS; d++) begin
                if (lane_q[i][4*d +: 4] != 4'd0) cnt = DW'(d + 1);
            end
            lane_digits[i*DW +: DW] = cnt;
            for (int d = 0; d < DIGITS; d++) begin
                if (d < int'(cnt)) lane_ascii[(i*DIGITS + d)*8 +: 8] = {4'h3, lane_q[i][4*d +: 4]};
            end
        end
    end

endmodule

// File: tb/tb_ascii_lane_counter.sv
// Bench for ascii_lane_counter: a directed vector table, hand-written reset
// sequences, then random traffic compared against an integer model.
module tb_ascii_lane_counter;

    localparam int     LANES       = 4;
    localparam int     DIGITS      = 7;
    localparam int     START_VALUE = 1;
    localparam int     DW          = $clog2(DIGITS + 1);
    localparam int     AW          = LANES * 8 * DIGITS;
    localparam longint MAXV        = 64'd9999999;

    logic                   clk = 1'b0;
    logic                   reset, load_en, count_en;
    logic [4*DIGITS-1:0]    load_value;
    logic                   lanes_valid, overflow, load_error;
    logic [AW-1:0]          lane_ascii;
    logic [LANES*DW-1:0]    lane_digits;

    ascii_lane_counter #(.LANES(LANES), .DIGITS(DIGITS), .START_VALUE(START_VALUE)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_value (load_value),
        .count_en   (count_en),
        .lanes_valid(lanes_valid),
        .lane_ascii (lane_ascii),
        .lane_digits(lane_digits),
        .overflow   (overflow),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                le;
        logic [4*DIGITS-1:0] lv;
        logic                ce;
        logic                v;
        logic                o;
        logic                e;
        logic                chk;
        longint              base;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: integer base value plus flags.
    bit     m_valid, m_init, m_ovf, m_err, m_known;
    longint m_base;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int num_digits(input longint v);
        longint t;
        int     n;
        n = 1;
        t = v;
        while (t >= 10) begin
            t = t / 10;
            n++;
        end
        return n;
    endfunction

    function automatic logic [8*DIGITS-1:0] exp_str(input longint v);
        logic [8*DIGITS-1:0] s;
        longint              t;
        int                  n;
        n = num_digits(v);
        s = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (d < n) s[8*d +: 8] = 8'h30 + 8'(t % 10);
            t = t / 10;
        end
        return s;
    endfunction

    function automatic logic [4*DIGITS-1:0] int2bcd(input longint v);
        logic [4*DIGITS-1:0] r;
        longint              t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic longint bcd2int(input logic [4*DIGITS-1:0] b);
        longint r;
        r = 0;
        for (int d = DIGITS - 1; d >= 0; d--) r = r * 10 + longint'(b[4*d +: 4]);
        return r;
    endfunction

    function automatic bit bcd_bad(input logic [4*DIGITS-1:0] b);
        bit bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) if (b[4*d +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    task automatic check_lanes(input string tag, input longint base);
        logic [AW-1:0]       ea;
        logic [LANES*DW-1:0] ed;
        for (int i = 0; i < LANES; i++) begin
            ea[i*8*DIGITS +: 8*DIGITS] = exp_str(base + i);
            ed[i*DW +: DW]             = DW'(num_digits(base + i));
        end
        check({tag, " ascii"},  256'(lane_ascii),  256'(ea));
        check({tag, " digits"}, 256'(lane_digits), 256'(ed));
    endtask

    task automatic check_flags(input string tag, input logic v, input logic o, input logic e);
        check({tag, " valid"},      256'(lanes_valid), 256'(v));
        check({tag, " overflow"},   256'(overflow),    256'(o));
        check({tag, " load_error"}, 256'(load_error),  256'(e));
    endtask

    // Present inputs, take one rising edge, settle 1 time unit past it.
    task automatic drive(input logic le, input logic [4*DIGITS-1:0] lv, input logic ce);
        load_en    = le;
        load_value = lv;
        count_en   = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic le, input logic [4*DIGITS-1:0] lv, input logic ce,
                           input logic v, input logic o, input logic e,
                           input logic chk, input longint base);
        vec_t t;
        t.le = le; t.lv = lv; t.ce = ce; t.v = v; t.o = o; t.e = e; t.chk = chk; t.base = base;
        tbl.push_back(t);
    endtask

    task automatic apply_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            drive(tbl[k].le, tbl[k].lv, tbl[k].ce);
            check_flags($sformatf("vec%0d", k), tbl[k].v, tbl[k].o, tbl[k].e);
            if (tbl[k].chk) check_lanes($sformatf("vec%0d", k), tbl[k].base);
        end
    endtask

    // Assert reset between edges and check it acts without a clock edge.
    task automatic mid_reset(input string tag);
        load_en  = 1'b0;
        count_en = 1'b0;
        #3 reset = 1'b1;
        #1;
        check_flags({tag, " async"}, 1'b0, 1'b0, 1'b0);
        check_lanes({tag, " async"}, START_VALUE);
        @(posedge clk);
        #1;
        check({tag, " held valid"}, 256'(lanes_valid), 256'(0));
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_flags({tag, " release"}, 1'b1, 1'b0, 1'b0);
        check_lanes({tag, " release"}, START_VALUE);
    endtask

    logic [4*DIGITS-1:0] r_lv;
    logic                r_le, r_ce;
    int                  sel;
    longint              lv_int;

    initial begin
        // Directed table: starts in INIT at base 1 just after reset release.
        add_vec(0, 0, 0, 1, 0, 0, 1, 1);                        // 0  INIT -> RUN
        for (int k = 0; k < 5; k++) add_vec(0, 0, 0, 1, 0, 0, 1, 1); // 1-5 hold
        add_vec(0, 0, 1, 1, 0, 0, 1, 5);                        // 6
        add_vec(0, 0, 1, 1, 0, 0, 1, 9);                        // 7
        add_vec(1, 28'h9999996, 1, 0, 0, 0, 1, 9999996);        // 8  load wins
        add_vec(0, 0, 1, 1, 0, 0, 1, 9999996);                  // 9
        add_vec(0, 0, 1, 0, 1, 0, 1, 9999996);                  // 10 overflow
        add_vec(0, 0, 1, 0, 1, 0, 1, 9999996);                  // 11 frozen
        add_vec(1, 28'h5, 0, 0, 0, 0, 1, 5);                    // 12
        add_vec(0, 0, 0, 1, 0, 0, 1, 5);                        // 13
        add_vec(1, 28'h100, 1, 0, 0, 0, 1, 100);                // 14 load beats advance
        add_vec(0, 0, 0, 1, 0, 0, 1, 100);                      // 15
        add_vec(0, 0, 1, 1, 0, 0, 1, 104);                      // 16
        add_vec(1, 28'hA0, 0, 0, 0, 1, 0, 0);                   // 17 bad nibble
        add_vec(0, 0, 1, 0, 0, 1, 0, 0);                        // 18
        add_vec(1, 28'h42, 0, 0, 0, 0, 1, 42);                  // 19 recovery
        add_vec(0, 0, 1, 1, 0, 0, 1, 42);                       // 20
        add_vec(0, 0, 1, 1, 0, 0, 1, 46);                       // 21
        add_vec(1, 28'h9999993, 0, 0, 0, 0, 1, 9999993);        // 22
        add_vec(0, 0, 0, 1, 0, 0, 1, 9999993);                  // 23
        add_vec(0, 0, 1, 0, 1, 0, 1, 9999993);                  // 24 top would be 10000000
        add_vec(1, 28'h9999992, 0, 0, 0, 0, 1, 9999992);        // 25
        add_vec(0, 0, 0, 1, 0, 0, 1, 9999992);                  // 26
        add_vec(0, 0, 1, 1, 0, 0, 1, 9999996);                  // 27 top lands on 9999999
        add_vec(0, 0, 1, 0, 1, 0, 1, 9999996);                  // 28
        add_vec(1, 28'h9999997, 0, 0, 1, 0, 0, 0);              // 29 load overflows
        add_vec(0, 0, 1, 0, 1, 0, 0, 0);                        // 30
        add_vec(1, 28'h9999996, 0, 0, 0, 0, 1, 9999996);        // 31
        add_vec(0, 0, 0, 1, 0, 0, 1, 9999996);                  // 32
        add_vec(0, 0, 1, 0, 1, 0, 1, 9999996);                  // 33

        reset      = 1'b1;
        load_en    = 1'b0;
        count_en   = 1'b0;
        load_value = '0;
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check_lanes("reset", START_VALUE);
        reset = 1'b0;

        apply_range(0, 0);
        check("first lane0 string", 256'(lane_ascii[8*DIGITS-1:0]), 256'(56'h31));
        check("first digits", 256'(lane_digits), 256'({3'd1, 3'd1, 3'd1, 3'd1}));
        apply_range(1, 7);
        check("base9 digits", 256'(lane_digits), 256'({3'd2, 3'd2, 3'd2, 3'd1}));
        check("base9 lane1 low bytes", 256'(lane_ascii[8*DIGITS +: 16]), 256'(16'h3130));
        apply_range(8, tbl.size() - 1);

        mid_reset("reset from halt");
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        check_lanes("pre mid-run reset", 9);
        mid_reset("reset mid-run");

        m_valid = 1; m_init = 0; m_ovf = 0; m_err = 0; m_known = 1; m_base = START_VALUE;

        for (int n = 0; n < 600; n++) begin
            r_le = ($urandom_range(0, 11) == 0);
            r_ce = ($urandom_range(0, 3) != 0);
            sel  = $urandom_range(0, 7);
            if (sel < 3) lv_int = MAXV - longint'($urandom_range(0, 30));
            else         lv_int = longint'($urandom_range(0, 9999999));
            r_lv = int2bcd(lv_int);
            if (sel == 7) r_lv[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));

            drive(r_le, r_lv, r_ce);

            if (r_le) begin
                m_ovf = 0; m_err = 0; m_valid = 0;
                if (bcd_bad(r_lv)) begin
                    m_err = 1; m_init = 0; m_known = 0;
                end else if (bcd2int(r_lv) + LANES - 1 > MAXV) begin
                    m_ovf = 1; m_init = 0; m_known = 0;
                end else begin
                    m_base = bcd2int(r_lv); m_known = 1; m_init = 1;
                end
            end else if (m_init) begin
                m_init  = 0;
                m_valid = 1;
            end else if (m_valid && r_ce) begin
                if (m_base + 2*LANES - 1 > MAXV) begin
                    m_ovf   = 1;
                    m_valid = 0;
                end else begin
                    m_base = m_base + LANES;
                end
            end

            check_flags($sformatf("rnd%0d", n), m_valid, m_ovf, m_err);
            if (m_known) check_lanes($sformatf("rnd%0d", n), m_base);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
